// File: rtl/iob_cfg_loader.sv
// Serial config writer: hunts a sync byte, shifts in per-block TSMUX/DORREG fields, commits atomically on even parity.
// Latency: outputs update on the edge after the parity bit; CFG_DONE pulses for the cycle that follows.
// Backpressure: none; CFG_EN=0 freezes HUNT/LOAD/PAR, and the COMMIT cycle always completes.
module iob_cfg_loader #(
  parameter int          NIOB = 4,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic                IOCLK,
  input  logic                RST,
  input  logic                CFG_DIN,
  input  logic                CFG_EN,
  output logic [2*NIOB-1:0]   TSMUX_OUT,
  output logic [NIOB-1:0]     DORREG_OUT,
  output logic                CFG_DONE,
  output logic                CFG_ERR,
  output logic                BUSY
);

  localparam int PW = 3 * NIOB;
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [1:0] {HUNT, LOAD, PAR, COMMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  // Only the seven most recent bits are kept: the current bit always
  // completes the byte, so the oldest bit of the 8-bit window is never needed.
  logic [6:0]      r_sync;
  logic [PW-1:0]   r_shadow;
  logic [CW-1:0]   r_cnt;
  logic            r_par;

  logic [7:0]      w_sync_win;
  logic            w_lock;
  logic            w_load;
  logic            w_par_bad;
  logic            w_commit;
  logic [2*NIOB-1:0] w_tsmux;
  logic [NIOB-1:0]   w_dorreg;

  assign w_sync_win = {r_sync, CFG_DIN};
  assign BUSY       = (r_state != HUNT);

  // State register.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) r_state <= HUNT;
    else     r_state <= w_next;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    w_next    = r_state;
    w_lock    = 1'b0;
    w_load    = 1'b0;
    w_par_bad = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      HUNT: begin
        if (CFG_EN && (w_sync_win == SYNC)) begin
          w_lock = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        if (CFG_EN) begin
          w_load = 1'b1;
          if (r_cnt == CW'(PW - 1)) w_next = PAR;
        end
      end
      PAR: begin
        if (CFG_EN) begin
          if (r_par ^ CFG_DIN) begin
            w_par_bad = 1'b1;
            w_next    = HUNT;
          end else begin
            w_next    = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = HUNT;
      end
      default: w_next = HUNT;
    endcase
  end

  // Shadow holds the first payload bit at the MSB; unpack block i from its 3-bit slot.
  always_comb begin
    w_tsmux  = '0;
    w_dorreg = '0;
    for (int i = 0; i < NIOB; i++) begin
      w_tsmux[2*i+1] = r_shadow[PW-1-3*i];
      w_tsmux[2*i]   = r_shadow[PW-2-3*i];
      w_dorreg[i]    = r_shadow[PW-3-3*i];
    end
  end

  // Sync shifter, payload shadow, running parity, committed outputs and flags.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_sync     <= '0;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_par      <= 1'b0;
      TSMUX_OUT  <= '0;
      DORREG_OUT <= '0;
      CFG_DONE   <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      CFG_DONE <= w_commit;
      if (r_state == HUNT && CFG_EN) r_sync <= w_sync_win[6:0];
      if (w_par_bad || w_commit)     r_sync <= '0;
      if (w_lock) begin
        r_cnt   <= '0;
        r_par   <= 1'b0;
        CFG_ERR <= 1'b0;
      end
      if (w_load) begin
        r_shadow <= {r_shadow[PW-2:0], CFG_DIN};
        r_par    <= r_par ^ CFG_DIN;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_par_bad) begin
        CFG_ERR  <= 1'b1;
        r_shadow <= '0;
      end
      if (w_commit) begin
        TSMUX_OUT  <= w_tsmux;
        DORREG_OUT <= w_dorreg;
      end
    end
  end

endmodule

// File: tb/tb_iob_cfg_loader.sv
// Randomised frame driver with a scoreboard monitor for iob_cfg_loader.
// Expected commits are queued by the driver and popped by the monitor on CFG_DONE.
// Between commits the monitor requires the outputs to hold their last committed value.
module tb_iob_cfg_loader;
  localparam int NIOB = 4;
  localparam int PW   = 3 * NIOB;

  logic IOCLK = 1'b0;
  logic RST, CFG_DIN, CFG_EN;
  logic [2*NIOB-1:0] TSMUX_OUT;
  logic [NIOB-1:0]   DORREG_OUT;
  logic CFG_DONE, CFG_ERR, BUSY;

  iob_cfg_loader #(.NIOB(NIOB), .SYNC(8'hA5)) dut (
    .IOCLK(IOCLK), .RST(RST), .CFG_DIN(CFG_DIN), .CFG_EN(CFG_EN),
    .TSMUX_OUT(TSMUX_OUT), .DORREG_OUT(DORREG_OUT),
    .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .BUSY(BUSY)
  );

  always #5 IOCLK = ~IOCLK;

  int cyc = 0;
  always @(posedge IOCLK) cyc <= cyc + 1;

  typedef struct {
    logic [2*NIOB-1:0] t;
    logic [NIOB-1:0]   d;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 0;
  logic [2*NIOB-1:0] held_t = '0;
  logic [NIOB-1:0]   held_d = '0;
  logic [7:0] m_hist = '0;   // bits seen by the sync hunter since it was last cleared
  int stall_pct = 0;
  int last_pc   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic step(input logic en, input logic din);
    CFG_EN  = en;
    CFG_DIN = din;
    @(posedge IOCLK);
    #1;
  endtask

  // Random idle cycles, then one enabled bit; records the cycle the bit is presented.
  task automatic send_bit(input logic b);
    int k = 0;
    while (k < 6 && $urandom_range(99) < stall_pct) begin
      step(1'b0, 1'($urandom_range(1)));
      k++;
    end
    last_pc = cyc;
    step(1'b1, b);
  endtask

  // Would the hunter lock before the final bit of the sync byte?
  function automatic bit early_lock(input logic [7:0] h0, input logic [31:0] nz, input int n);
    logic [7:0] h = h0;
    logic [7:0] s = 8'hA5;
    for (int k = n - 1; k >= 0; k--) begin
      h = {h[6:0], nz[k]};
      if (h == s) return 1'b1;
    end
    for (int k = 7; k >= 1; k--) begin
      h = {h[6:0], s[k]};
      if (h == s) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic frame(input logic [2*NIOB-1:0] tp, input logic [NIOB-1:0] dp, input bit bad,
                       input int st_mid, input int st_par, input logic [31:0] noise, input int nn);
    logic bits[$];
    logic par;
    logic [31:0] nz;
    logic [7:0] s;
    int n;
    exp_t e;
    s  = 8'hA5;
    nz = noise;
    n  = nn;
    if (early_lock(m_hist, nz, n)) begin
      nz = '0;
      n  = 8;
    end
    for (int k = n - 1; k >= 0; k--) send_bit(nz[k]);
    chk("no_false_lock", {31'd0, BUSY}, 32'd0);
    for (int k = 7; k >= 0; k--) send_bit(s[k]);
    chk("busy_after_sync", {31'd0, BUSY}, 32'd1);
    chk("err_clear_at_sync", {31'd0, CFG_ERR}, 32'd0);
    par = bad;
    for (int i = 0; i < NIOB; i++) begin
      bits.push_back(tp[2*i+1]);
      bits.push_back(tp[2*i]);
      bits.push_back(dp[i]);
      par = par ^ tp[2*i+1] ^ tp[2*i] ^ dp[i];
    end
    for (int k = 0; k < PW; k++) begin
      if (k == 6) repeat (st_mid) step(1'b0, 1'($urandom_range(1)));
      send_bit(bits[k]);
    end
    repeat (st_par) step(1'b0, 1'($urandom_range(1)));
    send_bit(par);
    if (!bad) begin
      e.t = tp;
      e.d = dp;
      e.cyc = last_pc + 2;
      exp_q.push_back(e);
      step(1'b1, 1'($urandom_range(1)));   // commit cycle: this bit must be dropped
      chk("busy_after_commit", {31'd0, BUSY}, 32'd0);
      chk("err_after_good", {31'd0, CFG_ERR}, 32'd0);
    end else begin
      chk("err_after_bad", {31'd0, CFG_ERR}, 32'd1);
      chk("busy_after_bad", {31'd0, BUSY}, 32'd0);
    end
    m_hist = '0;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge IOCLK);
      if (mon_on) begin
        if (CFG_DONE) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {31'd0, CFG_DONE}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("commit_tsmux", {24'd0, TSMUX_OUT}, {24'd0, e.t});
            chk("commit_dorreg", {28'd0, DORREG_OUT}, {28'd0, e.d});
            chk("done_cycle", cyc, e.cyc);
            held_t = e.t;
            held_d = e.d;
          end
        end else begin
          chk("hold_outputs", {20'd0, TSMUX_OUT, DORREG_OUT}, {20'd0, held_t, held_d});
        end
      end
    end
  end

  initial begin
    logic [2*NIOB-1:0] t;
    logic [NIOB-1:0] d;
    logic bits[$];
    logic par;
    logic [7:0] s;
    s = 8'hA5;
    RST = 1'b1; CFG_EN = 1'b0; CFG_DIN = 1'b0;
    repeat (2) @(posedge IOCLK);
    #1;
    chk("rst_tsmux", {24'd0, TSMUX_OUT}, 32'd0);
    chk("rst_dorreg", {28'd0, DORREG_OUT}, 32'd0);
    chk("rst_done", {31'd0, CFG_DONE}, 32'd0);
    chk("rst_err", {31'd0, CFG_ERR}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    mon_on = 1;

    // Idle after reset.
    repeat (20) step(1'b0, 1'($urandom_range(1)));
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    chk("idle_tsmux", {24'd0, TSMUX_OUT}, 32'd0);

    // Reference frame: payload 011 100 000 111, parity 0.
    frame(8'b11_00_10_01, 4'b1001, 0, 0, 0, 32'd0, 0);
    chk("ref_tsmux_C9", {24'd0, TSMUX_OUT}, 32'hC9);
    chk("ref_dorreg_9", {28'd0, DORREG_OUT}, 32'h9);

    // Same frame with parity 1, then a different good frame stalled mid-payload and at parity.
    frame(8'b11_00_10_01, 4'b1001, 1, 0, 0, 32'd0, 0);
    chk("bad_keeps_tsmux", {24'd0, TSMUX_OUT}, 32'hC9);
    frame(8'b01_10_11_00, 4'b0110, 0, 5, 5, 32'd0, 0);
    frame(8'b11_00_10_01, 4'b1001, 0, 5, 5, 32'd0, 0);

    // Noise 5A, A4 ahead of the sync byte.
    frame(8'b10_01_00_11, 4'b0011, 0, 0, 0, 32'h5AA4, 16);

    // Reset part-way through LOAD.
    t = 8'b01_11_10_11;
    d = 4'b1101;
    par = 1'b0;
    for (int i = 0; i < NIOB; i++) begin
      bits.push_back(t[2*i+1]);
      bits.push_back(t[2*i]);
      bits.push_back(d[i]);
      par = par ^ t[2*i+1] ^ t[2*i] ^ d[i];
    end
    bits.push_back(par);
    for (int k = 7; k >= 0; k--) step(1'b1, s[k]);
    for (int k = 0; k < 6; k++) step(1'b1, bits[k]);
    RST = 1'b1;
    held_t = '0;
    held_d = '0;
    #1;
    chk("midrst_tsmux", {24'd0, TSMUX_OUT}, 32'd0);
    chk("midrst_dorreg", {28'd0, DORREG_OUT}, 32'd0);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    @(posedge IOCLK);
    #1;
    RST = 1'b0;
    m_hist = '0;
    for (int k = 6; k <= PW; k++) begin
      step(1'b1, bits[k]);
      m_hist = {m_hist[6:0], bits[k]};
    end
    chk("midrst_ignore_rest", {31'd0, BUSY}, 32'd0);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      stall_pct = $urandom_range(30);
      frame(8'($urandom), 4'($urandom), ($urandom_range(4) == 0), 0, 0,
            $urandom, $urandom_range(20));
    end
    stall_pct = 0;

    repeat (5) step(1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_cfg_loader.md
# iob_cfg_loader

Serial configuration writer for a bank of `ioblock54` I/O blocks. It hunts for a sync byte on a one-bit configuration stream and shifts in per-block TSMUX/DORREG fields. After an even-parity check it atomically commits the fields to the configuration outputs that drive each block's tristate mux and input-register select. It sits between the device configuration port and the I/O ring; the I/O blocks are the consumers of the values it writes.

## Interface
- `NIOB`, default 4: number of I/O blocks configured; payload length is 3*NIOB bits.
- `SYNC`, default 8'hA5: sync byte that starts a configuration frame.
- `IOCLK` input 1: clock; all state changes on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `CFG_DIN` input 1: serial configuration data, MSB-first.
- `CFG_EN` input 1: qualifies `CFG_DIN`; a bit is consumed only on edges where `CFG_EN`=1.
- `TSMUX_OUT` output 2*NIOB: committed TSMUX per block; block i occupies bits [2i+1:2i].
- `DORREG_OUT` output NIOB: committed DORREG per block; block i occupies bit i.
- `CFG_DONE` output 1: one-cycle pulse when a frame commits.
- `CFG_ERR` output 1: sticky parity-error flag.
- `BUSY` output 1: high whenever the FSM is not in HUNT.

## Operation
- Reset values:
  - `TSMUX_OUT` all 0, so every pin is tristated.
  - `DORREG_OUT` all 0, so each block's input is direct from the pin.
  - `CFG_DONE`=0, `CFG_ERR`=0, `BUSY`=0.
  - FSM in HUNT; sync shifter, shadow register and bit counter all cleared.
- FSM states: HUNT, LOAD, PAR, COMMIT.
- HUNT:
  - Each enabled bit shifts into an 8-bit shifter (new bit into LSB).
  - When the shifter value including the current bit equals `SYNC`, go to LOAD, clear the bit counter and clear `CFG_ERR`.
- LOAD:
  - Each enabled bit goes into the shadow register in payload order: block 0 first, per block TSMUX[1], TSMUX[0], DORREG.
  - The bit counter runs 0..3*NIOB-1. After the last payload bit, go to PAR.
- PAR:
  - One enabled bit is the parity bit; XOR of payload and parity bit must be 0 (even parity).
  - On match, go to COMMIT.
  - On mismatch, set `CFG_ERR`, leave the outputs unchanged, discard the shadow, clear the sync shifter and return to HUNT.
- COMMIT:
  - Unconditional, lasts one cycle and ignores `CFG_EN`.
  - Copy the shadow to `TSMUX_OUT`/`DORREG_OUT` in a single edge (all blocks update together), assert `CFG_DONE`, clear the sync shifter and go to HUNT.
- `CFG_EN`=0 in any of HUNT, LOAD or PAR: hold all state; no bit is consumed.
- Outputs change only at COMMIT or at reset; no partial frame is ever visible.
- Sync bytes are not recognised inside LOAD/PAR; those bits are payload.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous) and the frame is lost.

## Timing
- Sync: the sync byte's last bit is sampled at edge s; `BUSY` rises after edge s. The next enabled bit is payload bit 0.
- Parity: the parity bit is sampled at edge p (FSM enters COMMIT).
- Commit: at edge p+1, the outputs take their new values, `CFG_DONE`=1 for exactly the cycle after p+1, and `BUSY` falls after p+1.
- Error: `CFG_ERR` rises after edge p and remains high until the next sync detection or reset.
- Minimum frame length: 8 + 3*NIOB + 1 enabled cycles plus 1 commit cycle, i.e. 22 cycles for NIOB=4.
- Back-to-back: a new sync may begin with the first enabled bit after COMMIT; the shifter starts empty, so bits from the previous frame never form a sync.

## Test plan
- Reset then idle: `RST` pulse, `CFG_EN`=0 for 20 cycles -> `TSMUX_OUT`=8'h00, `DORREG_OUT`=4'h0, `BUSY`=0, `CFG_DONE` never asserts.
- Good frame, NIOB=4:
  - Stimulus: A5, payload 011 100 000 111, parity 0.
  - Response: `TSMUX_OUT`=8'hC9, `DORREG_OUT`=4'b1001 and one `CFG_DONE` pulse, exactly one cycle after the parity edge.
- Parity error:
  - Stimulus: the same frame with parity 1.
  - Response: outputs keep their prior values, `CFG_ERR`=1, no `CFG_DONE`.
  - A following good frame clears `CFG_ERR` at its sync and commits.
- Stall:
  - Stimulus: the good frame with `CFG_EN` deasserted for 5 cycles in the middle of the payload and during the parity slot.
  - Response: same result as the unstalled frame, with commit delayed by the stall count.
- Sync hunt: noise bits 0x5A, 0xA4 before A5 -> no false lock; lock occurs only after the full A5, and the frame commits correctly.
- Reset mid-LOAD: `RST` asserted after 6 payload bits -> outputs 0 immediately, `BUSY`=0; the remaining bits are ignored until a new sync arrives.
